// File: rtl/am2302_master.sv
// AM2302 (DHT22) single-wire read master: start pulse, response preamble, 40-bit pulse-width decode.
// Define AM2302_CKSUM_EN to enable the checksum compare; by default every frame is accepted.
module am2302_master #(
    parameter int CLK_PER_US    = 12,
    parameter int START_LOW_US  = 1000,
    parameter int BIT_THRESH_US = 48,
    parameter int TIMEOUT_US    = 200
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    inout  wire         SDA,
    output logic        busy,
    output logic        data_valid,
    output logic [39:0] data,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        cksum_err,
    output logic        timeout_err,
    output logic [3:0]  dbg_state_o
);

    localparam int PW = (CLK_PER_US > 2) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_TC   = PW'(CLK_PER_US - 1);
    localparam logic [15:0]   START_CNT  = 16'(START_LOW_US);
    localparam logic [15:0]   THRESH_CNT = 16'(BIT_THRESH_US);
    localparam logic [15:0]   TO_CNT     = 16'(TIMEOUT_US);

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_ERR_TO
    } state_t;

    state_t        state_q, state_d;
    logic          sda_m_q, sda_s_q, sda_prev_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   us_cnt_q;
    logic [5:0]    bit_cnt_q;
    logic [39:0]   shreg_q;
    logic [39:0]   data_q;
    logic          sda_oe_q, busy_q, data_valid_q, timeout_err_q;
    logic          rise, fall, us_tick, timed_out, bit_val, frame_ok;

    assign rise      = sda_s_q & ~sda_prev_q;
    assign fall      = ~sda_s_q & sda_prev_q;
    assign us_tick   = (presc_q == PRESC_TC);
    assign timed_out = (us_cnt_q == TO_CNT);
    assign bit_val   = (us_cnt_q >= THRESH_CNT);

`ifdef AM2302_CKSUM_EN
    logic [7:0] sum;
    logic       cksum_err_q;
    assign sum       = shreg_q[39:32] + shreg_q[31:24] + shreg_q[23:16] + shreg_q[15:8];
    assign frame_ok  = (sum == shreg_q[7:0]);
    assign cksum_err = cksum_err_q;
`else
    assign frame_ok  = 1'b1;
    assign cksum_err = 1'b0;
`endif

    // Open drain: the master only ever pulls low; release is Z and the board pull-up restores high.
    assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
    assign busy        = busy_q;
    assign data_valid  = data_valid_q;
    assign data        = data_q;
    assign humidity    = data_q[39:24];
    assign temperature = data_q[23:8];
    assign timeout_err = timeout_err_q;
    assign dbg_state_o = state_q;

    // Request protocol: start is taken only in IDLE (busy low); busy then stays high until the
    // cycle that carries the data_valid, cksum_err or timeout_err pulse. Starts while busy are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_START_LOW;
            S_START_LOW: if (us_cnt_q == START_CNT) state_d = S_WAIT_RESP;
            S_WAIT_RESP: if (fall) state_d = S_RESP_LOW;
                         else if (timed_out) state_d = S_ERR_TO;
            S_RESP_LOW:  if (rise) state_d = S_RESP_HIGH;
                         else if (timed_out) state_d = S_ERR_TO;
            S_RESP_HIGH: if (fall) state_d = S_BIT_LOW;
                         else if (timed_out) state_d = S_ERR_TO;
            S_BIT_LOW:   if (rise) state_d = S_BIT_HIGH;
                         else if (timed_out) state_d = S_ERR_TO;
            S_BIT_HIGH:  if (fall) state_d = (bit_cnt_q == 6'd0) ? S_CHECK : S_BIT_LOW;
                         else if (timed_out) state_d = S_ERR_TO;
            S_CHECK:     state_d = S_IDLE;
            S_ERR_TO:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            sda_m_q       <= 1'b1;
            sda_s_q       <= 1'b1;
            sda_prev_q    <= 1'b1;
            presc_q       <= '0;
            us_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            data_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef AM2302_CKSUM_EN
            cksum_err_q   <= 1'b0;
`endif
        end else begin
            sda_m_q    <= SDA;
            sda_s_q    <= sda_m_q;
            sda_prev_q <= sda_s_q;
            state_q    <= state_d;

            // The edge-detect cycle counts as the first cycle of the new state, so a pulse of
            // N whole microseconds reads back as exactly N at the closing edge.
            if (state_d != state_q) begin
                presc_q  <= PW'(1);
                us_cnt_q <= '0;
            end else begin
                presc_q <= us_tick ? '0 : presc_q + PW'(1);
                if (us_tick && us_cnt_q != 16'hFFFF)
                    us_cnt_q <= us_cnt_q + 16'd1;
            end

            sda_oe_q      <= (state_d == S_START_LOW);
            busy_q        <= (state_d != S_IDLE);
            data_valid_q  <= 1'b0;
            timeout_err_q <= (state_q == S_ERR_TO);
`ifdef AM2302_CKSUM_EN
            cksum_err_q   <= 1'b0;
`endif

            case (state_q)
                S_RESP_HIGH: if (fall) bit_cnt_q <= 6'd39;
                S_BIT_HIGH: begin
                    if (fall) begin
                        shreg_q <= {shreg_q[38:0], bit_val};
                        if (bit_cnt_q != 6'd0)
                            bit_cnt_q <= bit_cnt_q - 6'd1;
                    end
                end
                S_CHECK: begin
                    if (frame_ok) begin
                        data_q       <= shreg_q;
                        data_valid_q <= 1'b1;
                    end
`ifdef AM2302_CKSUM_EN
                    else begin
                        cksum_err_q <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/am2302_master.md
Name: am2302_master

Overview:
- Single-wire bus master that performs one AM2302 (DHT22) read transaction when `start` is pulsed.
- Drives the host start pulse, checks the sensor's response preamble and samples 40 data bits by high-pulse width.
- Checks the checksum and presents humidity and temperature words to the DW8051 peripheral register block.
- Sits directly upstream of the AM2302 sensor on the open-drain SDA line; the board provides an external pull-up.

Parameters:
- CLK_PER_US, 12, system clocks per microsecond (prescaler terminal count + 1); must be >= 2.
- START_LOW_US, 1000, duration the master holds SDA low for the start pulse; sensor minimum is 800 us.
- BIT_THRESH_US, 48, data-bit high width at or above this value decodes as 1 (nominal widths: 0 = 26 us, 1 = 70 us).
- TIMEOUT_US, 200, maximum time allowed in any wait-for-edge state before a timeout error.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a read; ignored while busy.
- SDA  inout  1  open-drain bus; the master only ever drives 0 or Z.
- busy  output  1  high from the cycle after an accepted start until DONE/ERR returns to IDLE.
- data_valid  output  1  one-cycle pulse; `data`, `humidity`, `temperature` are updated in the same cycle.
- data  output  40  raw frame, MSB first as received.
- humidity  output  16  data[39:24].
- temperature  output  16  data[23:8].
- cksum_err  output  1  one-cycle pulse on checksum mismatch.
- timeout_err  output  1  one-cycle pulse when a phase exceeds TIMEOUT_US.

Behaviour:
- Reset (async, RST_N=0):
  - SDA released (Z); all outputs 0; state IDLE.
  - Prescaler and counters cleared.
  - A reset during a transfer releases SDA immediately, without waiting for a clock.
- Input path:
  - SDA is sampled through a 2-FF synchronizer into sda_s.
  - Edges are detected against the previous sda_s, so edge detection lags the pin by 2-3 CLK.
- Timebase:
  - The prescaler counts 0..CLK_PER_US-1 and emits `us_tick` at terminal count.
  - us_cnt is 16 bits, cleared on every state entry, incremented on `us_tick`, and saturates at 0xFFFF.
- State machine:
  - IDLE: SDA=Z. `start` -> START_LOW; busy=1 next cycle.
  - START_LOW: drive SDA=0. When us_cnt==START_LOW_US -> release SDA, go to WAIT_RESP.
  - WAIT_RESP: SDA=Z. sda_s falling edge -> RESP_LOW. us_cnt==TIMEOUT_US -> ERR_TO.
  - RESP_LOW: rising edge -> RESP_HIGH. Timeout -> ERR_TO.
  - RESP_HIGH: falling edge -> BIT_LOW with bit_cnt=39. Timeout -> ERR_TO.
  - BIT_LOW: rising edge -> BIT_HIGH. Timeout -> ERR_TO.
  - BIT_HIGH, on falling edge:
    - Shift (us_cnt >= BIT_THRESH_US) into shreg LSB.
    - If bit_cnt==0 -> CHECK; otherwise decrement bit_cnt and go to BIT_LOW.
    - Timeout -> ERR_TO.
  - CHECK (1 cycle): sum = shreg[39:32]+shreg[31:24]+shreg[23:16]+shreg[15:8], mod 256.
    - sum == shreg[7:0]: load `data`, pulse data_valid, go to IDLE.
    - Otherwise: pulse cksum_err; `data` is not updated; go to IDLE.
  - ERR_TO (1 cycle): pulse timeout_err, release SDA, go to IDLE. `data` is not updated.
- Returning to IDLE clears busy in the same cycle as the data_valid, cksum_err or timeout_err pulse.
- The sensor's trailing 50 us low after bit 0 is ignored.
- A rising and falling edge seen within the same sample both count once, edge tested before timeout.
- A timeout compare hit in the same cycle as a valid edge: the edge wins.
- The master never drives SDA high.
- `start` while busy is dropped (not queued).

Optional Feature:
- Macro: AM2302_CKSUM_EN.
- Defined: checksum compare as in CHECK; mismatch pulses cksum_err and suppresses data_valid.
- Undefined: no adder; cksum_err is tied 0; CHECK always loads `data` and pulses data_valid.

Test Plan:
- Pulse start; sensor model returns 0x1234567814 (CLK_PER_US=12) -> SDA low 1000 us, then after the frame: data_valid=1 once, data=0x1234567814, humidity=0x1234, temperature=0x5678, cksum_err=0.
- Model data 0x1234567815 -> cksum_err pulses once, data_valid=0, `data` keeps its previous value; with the macro undefined, data_valid=1 and data=0x1234567815.
- No sensor (pull-up only) -> timeout_err pulses 1200 us (±1 us) after start; busy falls in the same cycle; SDA=Z.
- Second start pulsed 300 us into a transfer -> ignored; exactly one data_valid; busy stays continuously high until it.
- RST_N low at bit 20 of a frame -> SDA=Z immediately, all outputs 0; the next start after the sensor model's 1 ms idle completes normally with 0x1234567814.
- Sensor high widths swept 40/47/48/55 us -> the bit decodes as 0/0/1/1.
